// File: rtl/mac_seq_pkg.sv
// Shared definitions for the MAC array sequencer and the mesh controllers
// that reuse its index counter.
package mac_seq_pkg;

  localparam int DEFAULT_N  = 4;
  localparam int DEFAULT_IW = $clog2(DEFAULT_N);
  localparam int DEFAULT_AW = 2 * DEFAULT_IW;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } seq_state_t;

endpackage

// File: rtl/mac_index_counter.sv
// Nested i/j/k index counter (k innermost). It saturates at the terminal
// count instead of wrapping i, so the owner decides when a sweep ends.
module mac_index_counter
  import mac_seq_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic [IW-1:0] k,
  output logic          k_last,
  output logic          tc
);

  logic i_last;
  logic j_last;

  assign k_last = (k == IW'(N - 1));
  assign j_last = (j == IW'(N - 1));
  assign i_last = (i == IW'(N - 1));
  assign tc     = i_last && j_last && k_last;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (en && !tc) begin
      k <= k_last ? '0 : k + 1'b1;
      if (k_last) begin
        j <= j_last ? '0 : j + 1'b1;
        if (j_last) begin
          i <= i + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mac_array_sequencer.sv
// Sequencer for a shared MAC datapath computing C = A x B over NxN matrices;
// strobes trail the issued addresses by the one-cycle memory read latency.
module mac_array_sequencer
  import mac_seq_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int IW = $clog2(N),
  parameter int AW = 2 * IW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          STALL,
  input  logic [2:0]    SHIFT,
  output logic [AW-1:0] ADDR_A,
  output logic [AW-1:0] ADDR_B,
  output logic          ENa,
  output logic          ENr,
  output logic          CLR_ACC,
  output logic [2:0]    BSEL,
  output logic          WR_C,
  output logic [AW-1:0] ADDR_C,
  output logic          BUSY,
  output logic          DONE
);

  seq_state_t state, state_nxt;

  logic [IW-1:0] i, j, k;
  logic          k_last, tc;
  logic          accept, issue;

  logic          v1, last1, v2;
  logic [AW-1:0] addr_c1, addr_c2;

  assign accept = (state == IDLE) && START;
  assign issue  = (state == RUN) && !STALL;

  mac_index_counter #(.N(N), .IW(IW)) u_idx (
    .clk    (CLK),
    .rst_n  (RST),
    .clr    (accept),
    .en     (issue),
    .i      (i),
    .j      (j),
    .k      (k),
    .k_last (k_last),
    .tc     (tc)
  );

  assign ADDR_A = {i, k};
  assign ADDR_B = {k, j};
  assign ADDR_C = addr_c2;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      BSEL  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        BSEL <= SHIFT;
      end
    end
  end

  // Stage 1 tracks the product whose operands are on the memory outputs;
  // stage 2 marks the element whose sum has just landed in Rr.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      v1      <= 1'b0;
      last1   <= 1'b0;
      v2      <= 1'b0;
      addr_c1 <= '0;
      addr_c2 <= '0;
    end else if (!STALL) begin
      v1      <= (state == RUN);
      last1   <= k_last;
      addr_c1 <= {i, j};
      v2      <= v1 && last1;
      addr_c2 <= addr_c1;
    end
  end

  always_comb begin
    state_nxt = state;
    ENa       = 1'b0;
    ENr       = 1'b0;
    CLR_ACC   = 1'b0;
    WR_C      = 1'b0;
    case (state)
      IDLE:    if (START) state_nxt = RUN;
      RUN:     if (!STALL && tc) state_nxt = DRAIN;
      DRAIN:   if (!STALL && v2 && !v1) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Strobes are suppressed while stalled and during the reset cycle itself.
    if (!STALL && RST) begin
      ENa     = v1;
      ENr     = v1 && last1;
      CLR_ACC = v1 && last1;
      WR_C    = v2;
    end
  end

  assign BUSY = (state == RUN) || (state == DRAIN);
  assign DONE = (state == FIN);

endmodule

// File: doc/mac_array_sequencer.md
Name: mac_array_sequencer

Overview:
- Sequencer for one shared MAC datapath (4x4 signed multiplier, 12-bit adder, Ra accumulator register, Rr result register, barrel shifter) computing C = A x B for NxN matrices of 4-bit signed coefficients.
- Generates read addresses into the A and B coefficient memories, which are synchronous-read with 1-cycle latency.
- Drives the Ra/Rr enables, the accumulator clear and the barrel-shift select.
- Emits write strobes/addresses for the C result store; start/busy/done handshake toward the host FSM.

Parameters:
- N, 4, matrix dimension (power of two, 2..16)
- IW, $clog2(N), width of each i/j/k index
- AW, 2*IW, width of A/B/C memory addresses

Ports:
- CLK  in  1  master clock
- RST  in  1  master reset; one clock, reset synchronous and active-low
- START  in  1  begin a multiply; sampled only in IDLE
- STALL  in  1  freeze sequencing (downstream C store not ready)
- SHIFT  in  3  barrel-shift select; captured on accepted START
- ADDR_A  out  AW  A read address = i*N+k
- ADDR_B  out  AW  B read address = k*N+j
- ENa  out  1  accumulator register load enable
- ENr  out  1  result register load enable
- CLR_ACC  out  1  synchronous clear of Ra, overrides ENa
- BSEL  out  3  barrel-shifter select (held through run)
- WR_C  out  1  C store write strobe (RES/MTX valid)
- ADDR_C  out  AW  C write address = i*N+j
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle completion pulse

Behaviour:
- Reset (RST=0 at a CLK edge):
  - State goes to IDLE; i, j, k, pipeline flags cleared.
  - All outputs 0, including BSEL=0 and addresses 0.
  - Reset mid-operation aborts with no further strobes.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - START=1 → RUN, and SHIFT is latched into BSEL.
  - START is ignored in every other state.
- RUN:
  - One (i,j,k) per non-stalled cycle; k innermost, then j, then i.
  - Addresses are combinational from the registered counters.
  - After issuing (N-1,N-1,N-1) → DRAIN.
- Datapath strobes are a 1-cycle delayed copy of issue (memory latency):
  - every product: ENa=1;
  - product with k=N-1: ENa=1, ENr=1, CLR_ACC=1, so Rr=ACC+M_last and Ra=0 in the same edge (no bubble between elements).
- WR_C:
  - Asserted 1 cycle after ENr, with ADDR_C of that element.
  - ADDR_C is carried through a 2-stage pipeline.
- DRAIN:
  - Waits until the final WR_C has issued, then → FIN.
- FIN:
  - DONE=1 for exactly one cycle, then → IDLE.
  - BSEL holds its last value until the next START.
- BUSY:
  - 1 from the cycle after START is accepted through the final WR_C cycle.
  - 0 in FIN and IDLE.
- STALL=1:
  - Counters, addresses, pipeline flags and state hold.
  - ENa, ENr, CLR_ACC and WR_C are forced 0.
  - Memories re-present the same data, since addresses are stable.
  - On release, processing resumes with no lost or duplicated product.
  - STALL in IDLE/FIN has no effect.
- Counter wrap:
  - k wraps N-1→0 and increments j.
  - j wraps and increments i.
  - No wrap of i; the run ends instead.
- Timing, N=4, START sampled at edge 0, no stall:
  - RUN issue cycles 1..64.
  - First ENa at cycle 2; first ENr at 5; first WR_C at 6 with ADDR_C=0.
  - Last ENr at 65; last WR_C at 66 with ADDR_C=15.
  - DONE at 67; BUSY high for cycles 1..66.
- General latency: N³+3 cycles from START to DONE.

Decomposition:
- Shared package mac_seq_pkg:
  - state enum (IDLE/RUN/DRAIN/FIN);
  - default N;
  - index/address width localparams.
- One sub-module, mac_index_counter:
  - nested i/j/k counter with enable;
  - last flags and a terminal-count output.
  - It is reused by later mesh controllers.

Test Plan:
- Reset/idle: RST=0 during RUN at cycle 20 → next cycle all outputs 0 and state IDLE; no WR_C afterward.
- Nominal N=4, A=identity, B[r][c]=r*4+c-8:
  - strobe timing exactly as in Behaviour;
  - 16 WR_C at cycles 6,10,…,66 with ADDR_C 0..15;
  - captured C equals B.
- Extreme values, A=B all -8, SHIFT=3 → every C element RES=256 (12-bit, no overflow); BSEL=3 during run and after DONE.
- Stall: STALL=1 for cycles 12..17 and for 3 cycles coinciding with a pending WR_C:
  - no strobes while stalled;
  - DONE delayed by exactly 9 cycles;
  - results identical to no-stall run.
- Handshake: START held high through the run and pulsed again while BUSY → ignored; a new START in the cycle after DONE starts a second run correctly.
- Small config N=2, random 4-bit signed A/B: results match the software reference; DONE at START+11.
